// File: rtl/ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation encodings, FSM state enumeration and the decided
// divide-by-zero quotient pattern.
package ex_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Wide enough for any supported WIDTH; users take the low WIDTH bits.
    localparam int                 MAX_W   = 64;
    localparam logic [MAX_W-1:0]   DIV0_LO = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } state_t;

    // Bit 1 of the opcode selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Datapath of the multiply/divide unit: operand latches, the 2*WIDTH
// accumulator (product or remainder:quotient), one shared WIDTH+1 bit
// adder/subtractor, sign fix-up negation and the HI/LO result registers.
module muldiv_datapath
    import ex_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             prep,
    input  logic             iter,
    input  logic             fix,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q;
    logic               neg_r;

    logic               is_div;
    logic               sgn;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     add_x;
    logic [WIDTH:0]     add_y;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   quo_neg;
    logic [WIDTH-1:0]   rem_neg;

    assign is_div = op_is_div(op_r);
    assign sgn    = op_is_signed(op_r);
    assign div0   = is_div && (b_r == '0);

    // Magnitudes for signed operations; unsigned operands pass unchanged.
    always_comb begin
        abs_a = (sgn && a_r[WIDTH-1]) ? -a_r : a_r;
        abs_b = (sgn && b_r[WIDTH-1]) ? -b_r : b_r;
    end

    // Shared adder: multiply adds the multiplicand to the upper half,
    // divide subtracts the divisor from the left-shifted remainder.
    always_comb begin
        add_x = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        add_y = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
        sum   = add_x + add_y + {{WIDTH{1'b0}}, is_div};
    end

    // Two's complement forms used by the sign fix-up step.
    always_comb begin
        acc_neg = -acc;
        quo_neg = -acc[WIDTH-1:0];
        rem_neg = -acc[2*WIDTH-1:WIDTH];
    end

    // Operand latching, iteration steps and HI/LO result writes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            opnd        <= '0;
            acc         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (load) begin
            op_r        <= op;
            a_r         <= data_a;
            b_r         <= data_b;
            div_by_zero <= 1'b0;
        end else if (prep) begin
            if (div0) begin
                div_by_zero <= 1'b1;
                hi          <= a_r;
                lo          <= DIV0_LO[WIDTH-1:0];
            end else begin
                neg_q <= sgn & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                neg_r <= sgn & a_r[WIDTH-1];
                if (is_div) begin
                    opnd <= abs_b;
                    acc  <= {{WIDTH{1'b0}}, abs_a};
                end else begin
                    opnd <= abs_a;
                    acc  <= {{WIDTH{1'b0}}, abs_b};
                end
            end
        end else if (iter) begin
            if (is_div) begin
                if (!sum[WIDTH]) begin
                    acc <= {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc <= {acc[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                if (acc[0]) begin
                    acc <= {sum, acc[WIDTH-1:1]};
                end else begin
                    acc <= {1'b0, acc[2*WIDTH-1:1]};
                end
            end
        end else if (fix) begin
            if (is_div) begin
                lo <= neg_q ? quo_neg : acc[WIDTH-1:0];
                hi <= neg_r ? rem_neg : acc[2*WIDTH-1:WIDTH];
            end else begin
                lo <= neg_q ? acc_neg[WIDTH-1:0] : acc[WIDTH-1:0];
                hi <= neg_q ? acc_neg[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// EX-stage multi-cycle multiply/divide unit: controlling FSM and
// iteration counter, driving the datapath and the pipeline stall.
module ex_muldiv_sequencer
    import ex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               load;
    logic               prep;
    logic               iter;
    logic               fix;
    logic               div0;

    // State and iteration counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and datapath strobes; flush squashes any in-flight work
    // before DONE, and a start that arrives with flush is not accepted.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        prep    = 1'b0;
        iter    = 1'b0;
        fix     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !flush) begin
                    load    = 1'b1;
                    state_n = ST_PREP;
                end
            end
            ST_PREP: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    prep = 1'b1;
                    if (div0) begin
                        state_n = ST_DONE;
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    iter = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_n = ST_FIX;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_n = ST_IDLE;
                end else begin
                    fix     = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign busy  = (state != ST_IDLE);
    assign done  = (state == ST_DONE);
    assign stall = (start && state == ST_IDLE) || (state != ST_IDLE && state != ST_DONE);

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .prep        (prep),
        .iter        (iter),
        .fix         (fix),
        .op          (op),
        .data_a      (data_a),
        .data_b      (data_b),
        .div0        (div0),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

endmodule

// File: doc/ex_muldiv_sequencer.md
Name: ex_muldiv_sequencer

Overview:
Multi-cycle multiply/divide unit beside the single-cycle ALU in the EX stage, with its controlling FSM. It accepts MULT/MULTU/DIV/DIVU requests from decode and runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles. It drives a stall to the pipeline while busy and publishes the HI/LO results.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
data_a  input  WIDTH  multiplicand or dividend
data_b  input  WIDTH  multiplier or divisor
flush  input  1  abort the current operation (branch or exception squash)
busy  output  1  high in every state except IDLE
stall  output  1  pipeline hold request
done  output  1  one-cycle pulse; hi/lo valid
hi  output  WIDTH  product upper half, or remainder
lo  output  WIDTH  product lower half, or quotient
div_by_zero  output  1  sticky until the next accepted start; set by DIV/DIVU with data_b == 0

Behaviour:
- Reset: the asynchronous assertion (reset == 0) forces state to IDLE and clears hi, lo, done, div_by_zero and the counter to 0. This happens immediately, including mid-operation. Outputs are 0 while reset is held.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - start == 1 and flush == 0: latch op, data_a and data_b; clear div_by_zero; go to PREP.
  - start while not in IDLE is ignored. There is no queueing.
- PREP (1 cycle):
  - Signed ops: take |a| and |b|; record neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
  - Unsigned ops: neg_q = neg_r = 0.
  - Divide with b == 0: set div_by_zero and go directly to DONE with hi = data_a and lo = all ones (decided result).
  - Otherwise: counter = 0; go to ITER.
- ITER (exactly WIDTH cycles; counter runs 0..WIDTH-1, then go to FIX):
  - Multiply: the accumulator is 2*WIDTH bits. If multiplier LSB == 1, add the multiplicand into the upper half. Then shift the whole accumulator right 1, keeping the adder carry-out.
  - Divide: shift the remainder:quotient pair left 1, then trial-subtract the divisor. If the result is non-negative, commit it and set the quotient LSB to 1.
- FIX (1 cycle):
  - Multiply: if neg_q, replace the full 2*WIDTH product with its two's complement.
  - Divide: if neg_q, negate the quotient; if neg_r, negate the remainder.
  - Write hi and lo.
- DONE (1 cycle): done = 1, then go to IDLE. hi and lo hold their values until the next FIX or reset.
- Latency: with start accepted at edge N, done is high in cycle N+WIDTH+3 (35 for WIDTH = 32). A divide by zero gives done at N+2.
- stall = (start & state == IDLE) | (state != IDLE & state != DONE). The pipeline is released in the same cycle done is high.
- Arithmetic:
  - DIV most-negative / -1 gives lo = 2^(WIDTH-1) (bit pattern 0x80000000) and hi = 0. No trap.
  - All arithmetic wraps modulo 2^WIDTH per half.
- flush:
  - In PREP, ITER or FIX: go to IDLE on the next edge; hi, lo and div_by_zero are unchanged; no done pulse.
  - In DONE: ignored, so done still pulses.
  - In IDLE: wins over start, so no accept.
- Simultaneous start and done: done occurs in DONE, not IDLE, so that start is ignored. The requester holds start until stall drops in IDLE.

Decomposition:
- Shared package ex_pkg holds:
  - op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - the state enumeration;
  - the DIV0_LO constant (all ones).
- One natural sub-module: muldiv_datapath. It holds the accumulator/remainder registers, the shared WIDTH+1-bit adder/subtractor and the negation logic, under control strobes from the FSM in the top.

Test Plan:
- MULTU 0xFFFFFFFF * 0xFFFFFFFF, start at cycle 0 -> done at cycle 35, hi = 0xFFFFFFFE, lo = 0x00000001, stall high cycles 0-34.
- MULT -3 (0xFFFFFFFD) * 5 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU 100 / 0 -> done at cycle 2, div_by_zero = 1, hi = 100, lo = 0xFFFFFFFF.
- Start MULTU 2*3; pulse start again at cycle 10 with other operands -> ignored; result hi = 0, lo = 6 at cycle 35; no second done.
- DIVU 100/7 completed (lo = 14, hi = 2); then start MULT; assert flush at cycle 20 -> IDLE at cycle 21, stall low, no done, hi = 2 and lo = 14 retained.
- Drive reset low at cycle 15 of a DIVU -> busy, stall, hi and lo all 0 immediately; after release, a new MULTU 4*4 -> lo = 16 at 35 cycles after its start.
